fetch_unit: RTL

- Instruction-fetch front end of the RISC-V pipeline: owns the architectural PC and issues word reads to instruction memory.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to the ID stage through a valid/ready handshake.
- Accepts branch/jump redirects resolved in ID and flushes wrong-path fetches.
- Exposes the current fetch PC for bench monitoring.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared constants and types for the RISC-V front end.
//               XLEN       - architectural data/address width
//               NOP_INSTR  - canonical NOP (addi x0, x0, 0)
//               fetch_entry_t - prefetch FIFO entry {instr, pc}
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO for the prefetch buffer. Pointers wrap
//               modulo DEPTH (power of two). Flush empties the FIFO in one
//               cycle and overrides push/pop.
// Ports       : clock    - rising-edge clock
//               reset    - asynchronous active-low reset
//               push_i   - write data_i at the tail
//               data_i   - entry to write
//               pop_i    - drop the head entry
//               flush_i  - discard all entries
//               count_o  - number of valid entries (0..DEPTH)
//               head_o   - head entry (meaningful only when count_o != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push;

  assign do_push = push_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every use of the head.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues one
//               word read per cycle to instruction memory, buffers returned
//               words with their PCs in a prefetch FIFO and hands them to ID
//               over a valid/ready handshake. Redirects from ID flush the
//               FIFO and bump a 1-bit epoch so wrong-path responses are dropped.
// Ports       : clock, reset           - clock / async active-low reset
//               imem_req, imem_addr    - fetch request and word address
//               imem_rdata, imem_rvalid- response, one cycle after request
//               id_ready               - ID consumes head entry
//               id_valid, id_instr,
//               id_pc                  - head entry (NOP / 0 when invalid)
//               redirect_valid,
//               redirect_target        - taken branch/jump from ID
//               pc                     - current fetch PC register
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [XLEN-1:0] pc_q,             pc_d;
  logic            inflight_q,       inflight_d;
  logic [XLEN-1:0] inflight_pc_q,    inflight_pc_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q,          epoch_d;

  logic             pop;
  logic             fifo_push;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occupancy;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid & id_ready;

  // Slots that will be committed after this edge: buffered entries plus the
  // outstanding response, minus the entry ID takes this cycle.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

  // Gated by reset so the request strobe is low for the whole reset period.
  assign imem_req  = reset & ~redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  // A redirect this cycle makes any arriving response wrong-path.
  assign fifo_push = imem_rvalid & inflight_q & (inflight_epoch_q == epoch_q)
                   & ~redirect_valid;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc_q;

  always_comb begin
    pc_d             = pc_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;
    if (redirect_valid) begin
      // Misaligned targets are truncated to the containing word.
      pc_d    = redirect_target & ~XLEN'(3);
      epoch_d = ~epoch_q;
    end else if (imem_req) begin
      pc_d             = pc_q + XLEN'(4);
      inflight_d       = 1'b1;
      inflight_pc_d    = pc_q;
      inflight_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (head_entry)
  );

  assign id_instr = id_valid ? head_entry.instr : NOP_INSTR;
  assign id_pc    = id_valid ? head_entry.pc    : '0;
  assign pc       = pc_q;

endmodule
`default_nettype wire
